// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receiver and transmitter:
//            FSM state encoding, frame geometry and the baud divisor helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // 8N1 frame: eight payload bits, LSB first.
  localparam int unsigned DATA_BITS = 8;

  // Clocks per bit. Integer division, so TX and RX built with the same
  // parameters always agree on the bit period.
  function automatic int unsigned div(input int unsigned f_clk,
                                      input int unsigned baudrate);
    return f_clk / baudrate;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Purpose  : Two-flop synchroniser for a single asynchronous input.
//            The reset value is a parameter so idle-high lines (UART, IR)
//            do not produce a false edge when reset is released.
// Ports    : clk  - destination clock
//            rst  - synchronous active-high reset
//            d_i  - asynchronous input
//            q_o  - synchronised output (2-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, LSB first. Samples the synchronised line at
//            mid-bit and presents each byte through a valid/ready hold
//            register. Framing and overrun errors are one-cycle pulses.
// Ports    : clk       - system clock, posedge
//            rst       - synchronous active-high reset
//            rx        - asynchronous serial line, idles high
//            ready     - consumer accepts data while valid is high
//            data      - last received byte, stable while valid is high
//            valid     - data holds an unconsumed byte
//            idle      - receiver FSM is in IDLE
//            frame_err - pulse: stop bit sampled low
//            overrun   - pulse: byte completed while valid & ~ready
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = 9600,
  parameter int unsigned F_CLK    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       idle,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV  = div(F_CLK, BAUDRATE);
  localparam int unsigned HALF = DIV / 2;

  localparam logic [31:0] CNT_HALF_LAST = 32'(HALF - 1);
  localparam logic [31:0] CNT_BIT_LAST  = 32'(DIV - 1);
  localparam logic [2:0]  IDX_LAST      = 3'(DATA_BITS - 1);

  // Below four clocks per bit the half-bit point collapses onto the edges.
  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: F_CLK/BAUDRATE must be at least 4");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Input synchroniser; resets high so reset release is not a start bit.
  // --------------------------------------------------------------------------
  logic rx_s;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  uart_state_e state_q,     state_d;
  logic [31:0] cnt_q,       cnt_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  data_q,      data_d;
  logic        valid_q,     valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q,   overrun_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The bit counter restarts at every sample point so all
  // later samples land exactly k*DIV clocks after the mid-start sample.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // Handshake consumes the byte; a load below overrides this.
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ready;
            // Returning to IDLE at mid-stop leaves half a bit to catch a
            // back-to-back start edge.
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      BREAK: begin
        // Wait out a held-low line so it cannot look like a new start bit.
        if (rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign idle      = (state_q == IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at F_CLK=1 MHz, 100 kbaud
//            (10 clocks per bit). Table of single frames plus directed
//            sequences for back-to-back, glitch, break, overrun and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DIV = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       idle;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .BAUDRATE (100_000),
    .F_CLK    (1_000_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .idle      (idle),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: running totals of accepted bytes and error pulses.
  int unsigned mon_xfer = 0;
  int unsigned mon_ferr = 0;
  int unsigned mon_ovr  = 0;
  logic [7:0]  rx_log [0:255];

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        rx_log[mon_xfer[7:0]] <= data;
        mon_xfer              <= mon_xfer + 1;
      end
      if (frame_err) mon_ferr <= mon_ferr + 1;
      if (overrun)   mon_ovr  <= mon_ovr + 1;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after posedge; checks happen at negedge.
  task automatic drive_phase();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) drive_phase();
  endtask

  task automatic send_bits(input logic [7:0] b);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         exp_xfer;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int unsigned x0, f0, o0;
    bit          seen;
    logic [7:0]  seq [4];

    vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_xfer: 1, exp_ferr: 0};
    vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_xfer: 1, exp_ferr: 0};
    vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_xfer: 1, exp_ferr: 0};
    vecs[3] = '{tx: 8'h3C, stop: 1'b0, exp_xfer: 0, exp_ferr: 1};
    vecs[4] = '{tx: 8'h5A, stop: 1'b1, exp_xfer: 1, exp_ferr: 0};
    vecs[5] = '{tx: 8'h81, stop: 1'b1, exp_xfer: 1, exp_ferr: 0};

    // ---------------- reset state ----------------
    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    repeat (3) drive_phase();
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle",  32'(idle),      32'd1);
    check("rst_valid", 32'(valid),     32'd0);
    check("rst_data",  32'(data),      32'd0);
    check("rst_ferr",  32'(frame_err), 32'd0);
    check("rst_ovr",   32'(overrun),   32'd0);
    drive_phase();
    hold(1'b1, DIV);

    // ---------------- single-frame table ----------------
    for (int v = 0; v < 6; v++) begin
      x0 = mon_xfer; f0 = mon_ferr; o0 = mon_ovr;
      send_bits(vecs[v].tx);
      hold(vecs[v].stop, DIV);
      hold(1'b1, 2 * DIV);
      @(negedge clk);
      check($sformatf("vec%0d_xfer", v), mon_xfer - x0, 32'(vecs[v].exp_xfer));
      check($sformatf("vec%0d_ferr", v), mon_ferr - f0, 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v),  mon_ovr - o0,  32'd0);
      check($sformatf("vec%0d_idle", v), 32'(idle),     32'd1);
      check($sformatf("vec%0d_valid", v), 32'(valid),   32'd0);
      if (vecs[v].exp_xfer > 0)
        check($sformatf("vec%0d_data", v), 32'(rx_log[x0[7:0]]), 32'(vecs[v].tx));
      drive_phase();
    end

    // ---------------- back-to-back frames ----------------
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55; seq[3] = 8'h80;
    x0 = mon_xfer; f0 = mon_ferr; o0 = mon_ovr;
    for (int k = 0; k < 4; k++) begin
      send_bits(seq[k]);
      hold(1'b1, DIV);
    end
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("b2b_xfer", mon_xfer - x0, 32'd4);
    check("b2b_ferr", mon_ferr - f0, 32'd0);
    check("b2b_ovr",  mon_ovr - o0,  32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("b2b_data%0d", k), 32'(rx_log[8'(x0 + k)]), 32'(seq[k]));
    drive_phase();

    // ---------------- 3-clock glitch ----------------
    x0 = mon_xfer; f0 = mon_ferr; o0 = mon_ovr;
    hold(1'b0, 3);
    rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!idle) seen = 1'b1;
    end
    check("glitch_left_idle", 32'(seen), 32'd1);
    drive_phase();
    hold(1'b1, DIV);
    @(negedge clk);
    check("glitch_idle",  32'(idle),     32'd1);
    check("glitch_valid", 32'(valid),    32'd0);
    check("glitch_xfer",  mon_xfer - x0, 32'd0);
    check("glitch_ferr",  mon_ferr - f0, 32'd0);
    check("glitch_ovr",   mon_ovr - o0,  32'd0);
    drive_phase();

    // ---------------- break: stop held low 30 clocks ----------------
    x0 = mon_xfer; f0 = mon_ferr;
    send_bits(8'h3C);
    hold(1'b0, 30);
    @(negedge clk);
    check("brk_ferr_once", mon_ferr - f0, 32'd1);
    check("brk_not_idle",  32'(idle),     32'd0);
    check("brk_valid",     32'(valid),    32'd0);
    drive_phase();
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("brk_idle_after", 32'(idle),     32'd1);
    check("brk_no_xfer",    mon_xfer - x0, 32'd0);
    drive_phase();
    send_bits(8'h12);
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("brk_next_xfer", mon_xfer - x0, 32'd1);
    check("brk_next_data", 32'(rx_log[x0[7:0]]), 32'h12);
    check("brk_ferr_total", mon_ferr - f0, 32'd1);
    drive_phase();

    // ---------------- overrun with ready low ----------------
    x0 = mon_xfer; o0 = mon_ovr;
    ready = 1'b0;
    send_bits(8'h11);
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("ovr1_valid", 32'(valid),    32'd1);
    check("ovr1_data",  32'(data),     32'h11);
    check("ovr1_ovr",   mon_ovr - o0,  32'd0);
    drive_phase();
    send_bits(8'h22);
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("ovr2_valid", 32'(valid),    32'd1);
    check("ovr2_data",  32'(data),     32'h22);
    check("ovr2_ovr",   mon_ovr - o0,  32'd1);
    check("ovr2_xfer",  mon_xfer - x0, 32'd0);
    drive_phase();
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_drop_valid", 32'(valid),    32'd0);
    check("ovr_accept",     mon_xfer - x0, 32'd1);
    check("ovr_accept_data", 32'(rx_log[x0[7:0]]), 32'h22);
    drive_phase();

    // ---------------- reset mid-DATA ----------------
    // Frame 0xF0: bits 0..3 low, reset lands as bit 4 (high) begins.
    x0 = mon_xfer; f0 = mon_ferr;
    hold(1'b0, DIV);
    for (int i = 0; i < 4; i++) hold(1'b0, DIV);
    rx  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_idle",  32'(idle),  32'd1);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data",  32'(data),  32'd0);
    drive_phase();
    rst = 1'b0;
    hold(1'b1, 5 * DIV);
    @(negedge clk);
    check("mid_rst_no_xfer", mon_xfer - x0, 32'd0);
    check("mid_rst_no_ferr", mon_ferr - f0, 32'd0);
    drive_phase();
    send_bits(8'hC3);
    hold(1'b1, 2 * DIV);
    @(negedge clk);
    check("post_rst_xfer", mon_xfer - x0, 32'd1);
    check("post_rst_data", 32'(rx_log[x0[7:0]]), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
